// File: rtl/microseq_pkg.sv
// Shared sequencer types: opcode/register aliases, sequencer states and
// interrupt line indices (index 0 has highest priority).
package microseq_pkg;

  typedef logic [7:0] opcode_t;
  typedef logic [7:0] reg8_t;

  // Sequencer states; encodings are fixed so the RTL can mirror them as
  // plain localparam constants.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    IRQ    = 2'd2
  } seq_state_t;

  // Interrupt line indices, highest priority first.
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_LCD    = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

endpackage

// File: rtl/microseq_if.sv
// Decoder <-> sequencer bundle. The master side (decoder, flags, memory,
// interrupt controller) drives control inputs; the slave side (microseq)
// returns the instruction register, step and interrupt-dispatch status.
interface microseq_if #(
  parameter int STEP_W  = 3,
  parameter int IR_W    = 8,
  parameter int NUM_IRQ = 5,
  parameter int IDX_W   = $clog2(NUM_IRQ)
);

  // Driven by the master side.
  logic               stall;
  logic               done;
  logic               is_cond;
  logic               cond_true;
  logic [STEP_W-1:0]  next_cond;
  logic               prefix;
  logic               halt;
  logic               ime;
  logic [NUM_IRQ-1:0] irq_pending;
  logic [IR_W-1:0]    d_in;

  // Driven by the sequencer.
  logic [IR_W-1:0]    ir;
  logic               ir_prefix;
  logic [STEP_W-1:0]  step;
  logic               irq_active;
  logic [IDX_W-1:0]   irq_idx;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               halted;
  logic               seq_err;

  modport master (
    output stall, done, is_cond, cond_true, next_cond, prefix, halt, ime,
           irq_pending, d_in,
    input  ir, ir_prefix, step, irq_active, irq_idx, irq_ack, halted, seq_err
  );

  modport slave (
    input  stall, done, is_cond, cond_true, next_cond, prefix, halt, ime,
           irq_pending, d_in,
    output ir, ir_prefix, step, irq_active, irq_idx, irq_ack, halted, seq_err
  );

endinterface

// File: rtl/microseq_irq_prio_enc.sv
// Fixed-priority encoder for interrupt requests: the lowest set index wins.
// Purely combinational so the interrupt controller can reuse it.
module irq_prio_enc #(
  parameter int NUM_IRQ = 5,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx,
  output logic [NUM_IRQ-1:0] o_onehot
);

  // Scan from the top so the last hit (lowest index) overrides.
  // NOTE: every output gets a default before the loop so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    o_valid  = |i_req;
    o_idx    = '0;
    o_onehot = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx    = IDX_W'(i);
        o_onehot = '0;
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/microseq.sv
// Instruction sequencer: holds the instruction register and step counter,
// tracks CB-page prefixes, HALT, prioritised interrupt dispatch, memory
// stalls and step-counter wrap detection.
module microseq
  import microseq_pkg::*;
#(
  parameter int STEP_W  = 3,
  parameter int IR_W    = 8,
  parameter int NUM_IRQ = 5,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input logic       clk,
  input logic       rst_n,
  microseq_if.slave bus
);

  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_HALTED = HALTED;
  localparam logic [1:0] ST_IRQ    = IRQ;

  // Registered state.
  logic [1:0]         r_state;
  logic [IR_W-1:0]    r_ir;
  logic               r_ir_prefix;
  logic [STEP_W-1:0]  r_step;
  logic [IDX_W-1:0]   r_irq_idx;
  logic [NUM_IRQ-1:0] r_irq_ack;
  logic               r_seq_err;

  // Next-state values.
  logic [1:0]         w_state_nxt;
  logic [IR_W-1:0]    w_ir_nxt;
  logic               w_ir_prefix_nxt;
  logic [STEP_W-1:0]  w_step_nxt;
  logic [IDX_W-1:0]   w_irq_idx_nxt;
  logic [NUM_IRQ-1:0] w_irq_ack_nxt;
  logic               w_seq_err_nxt;

  // Interrupt selection.
  logic               w_sel_valid;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [NUM_IRQ-1:0] w_sel_onehot;
  logic               w_take;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_prio (
    .i_req    (bus.irq_pending),
    .o_valid  (w_sel_valid),
    .o_idx    (w_sel_idx),
    .o_onehot (w_sel_onehot)
  );

  assign w_take = bus.ime & w_sel_valid;

  // Next-state decode. A stall keeps every register as-is and lets irq_ack
  // fall back to zero; done/is_cond are not looked at while stalled.
  always_comb begin
    w_state_nxt     = r_state;
    w_ir_nxt        = r_ir;
    w_ir_prefix_nxt = r_ir_prefix;
    w_step_nxt      = r_step;
    w_irq_idx_nxt   = r_irq_idx;
    w_irq_ack_nxt   = '0;
    w_seq_err_nxt   = r_seq_err;

    if (!bus.stall) begin
      case (r_state)
        ST_RUN, ST_IRQ: begin
          if (bus.done) begin
            w_step_nxt = '0;
            if (r_state == ST_IRQ) begin
              // End of dispatch: resume with the re-fetched opcode. Pending
              // requests are deliberately not re-checked here.
              w_state_nxt     = ST_RUN;
              w_ir_nxt        = bus.d_in;
              w_ir_prefix_nxt = 1'b0;
            end else if (bus.prefix) begin
              // Prefix binds to the next opcode; no interrupt may split them.
              w_ir_nxt        = bus.d_in;
              w_ir_prefix_nxt = 1'b1;
            end else if (w_take) begin
              // Enter dispatch; the fetched opcode is dropped and refetched.
              w_state_nxt     = ST_IRQ;
              w_irq_idx_nxt   = w_sel_idx;
              w_irq_ack_nxt   = w_sel_onehot;
              w_ir_nxt        = '0;
              w_ir_prefix_nxt = 1'b0;
            end else if (bus.halt) begin
              w_state_nxt = ST_HALTED;
            end else begin
              w_ir_nxt        = bus.d_in;
              w_ir_prefix_nxt = 1'b0;
            end
          end else if (bus.is_cond && !bus.cond_true) begin
            w_step_nxt = bus.next_cond;
          end else begin
            w_step_nxt = r_step + 1'b1;
            if (&r_step) begin
              w_seq_err_nxt = 1'b1;
            end
          end
        end

        ST_HALTED: begin
          w_step_nxt = '0;
          if (w_take) begin
            w_state_nxt     = ST_IRQ;
            w_irq_idx_nxt   = w_sel_idx;
            w_irq_ack_nxt   = w_sel_onehot;
            w_ir_nxt        = '0;
            w_ir_prefix_nxt = 1'b0;
          end else if (w_sel_valid) begin
            // Wake without servicing: interrupts are masked by ime.
            w_state_nxt     = ST_RUN;
            w_ir_nxt        = bus.d_in;
            w_ir_prefix_nxt = 1'b0;
          end
        end

        default: begin
          // Unused encoding: fall back to RUN.
          w_state_nxt = ST_RUN;
          w_step_nxt  = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous reset to NOP / RUN.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_ir        <= '0;
      r_ir_prefix <= 1'b0;
      r_step      <= '0;
      r_irq_idx   <= '0;
      r_irq_ack   <= '0;
      r_seq_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ir        <= w_ir_nxt;
      r_ir_prefix <= w_ir_prefix_nxt;
      r_step      <= w_step_nxt;
      r_irq_idx   <= w_irq_idx_nxt;
      r_irq_ack   <= w_irq_ack_nxt;
      r_seq_err   <= w_seq_err_nxt;
    end
  end

  assign bus.ir         = r_ir;
  assign bus.ir_prefix  = r_ir_prefix;
  assign bus.step       = r_step;
  assign bus.irq_idx    = r_irq_idx;
  assign bus.irq_ack    = r_irq_ack;
  assign bus.seq_err    = r_seq_err;
  assign bus.irq_active = (r_state == ST_IRQ);
  assign bus.halted     = (r_state == ST_HALTED);

endmodule

// File: tb/tb_microseq.sv
// Directed bench for microseq: reset, conditional branching, prefix/IRQ
// interaction, interrupt priority, HALT wake paths, stall and step wrap.
module tb_microseq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  microseq_if #(.STEP_W(3), .IR_W(8), .NUM_IRQ(5), .IDX_W(3)) bus ();

  microseq #(.STEP_W(3), .IR_W(8), .NUM_IRQ(5), .IDX_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.stall = 0; bus.done = 0; bus.is_cond = 0; bus.cond_true = 0;
    bus.next_cond = '0; bus.prefix = 0; bus.halt = 0; bus.ime = 0;
    bus.irq_pending = '0; bus.d_in = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ir",      32'(bus.ir), 0);
    check("rst_step",    32'(bus.step), 0);
    check("rst_active",  32'(bus.irq_active), 0);
    check("rst_halted",  32'(bus.halted), 0);
    check("rst_ack",     32'(bus.irq_ack), 0);
    check("rst_seq_err", 32'(bus.seq_err), 0);
    check("rst_idx",     32'(bus.irq_idx), 0);
    rst_n = 1'b1;

    // 1. Reset mid-sequence.
    bus.done = 1; bus.d_in = 8'h3E;
    cyc();
    check("t1_ir_load", 32'(bus.ir), 'h3E);
    bus.done = 0;
    cyc();
    cyc();
    check("t1_step2", 32'(bus.step), 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t1_async_ir",   32'(bus.ir), 0);
    check("t1_async_step", 32'(bus.step), 0);
    check("t1_async_run",  32'(bus.irq_active | bus.halted), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.done = 1; bus.d_in = 8'h06;
    cyc();
    check("t1_ir_06",   32'(bus.ir), 'h06);
    check("t1_step_06", 32'(bus.step), 0);

    // 2. Conditional branch.
    bus.done = 0; bus.is_cond = 1; bus.cond_true = 0; bus.next_cond = 3'd3;
    cyc();
    check("t2_branch", 32'(bus.step), 3);
    bus.is_cond = 0; bus.done = 1; bus.d_in = 8'h11;
    cyc();
    check("t2_done_step", 32'(bus.step), 0);
    check("t2_done_ir",   32'(bus.ir), 'h11);
    bus.done = 0; bus.is_cond = 1; bus.cond_true = 1;
    cyc();
    check("t2_cond_true", 32'(bus.step), 1);
    // done wins over a simultaneous false condition.
    bus.done = 1; bus.cond_true = 0; bus.next_cond = 3'd5; bus.d_in = 8'h22;
    cyc();
    check("t2_done_wins_step", 32'(bus.step), 0);
    check("t2_done_wins_ir",   32'(bus.ir), 'h22);
    bus.is_cond = 0;

    // 3. Prefix then IRQ.
    bus.ime = 1; bus.irq_pending = 5'b00100;
    bus.done = 1; bus.prefix = 1; bus.d_in = 8'h37;
    cyc();
    check("t3_pfx_ir",     32'(bus.ir), 'h37);
    check("t3_pfx_flag",   32'(bus.ir_prefix), 1);
    check("t3_pfx_noack",  32'(bus.irq_ack), 0);
    check("t3_pfx_noirq",  32'(bus.irq_active), 0);
    bus.prefix = 0; bus.d_in = 8'h55;
    cyc();
    check("t3_irq_active", 32'(bus.irq_active), 1);
    check("t3_irq_idx",    32'(bus.irq_idx), 2);
    check("t3_irq_ack",    32'(bus.irq_ack), 'b00100);
    check("t3_irq_ir",     32'(bus.ir), 0);
    check("t3_irq_pfx",    32'(bus.ir_prefix), 0);
    bus.done = 0; bus.irq_pending = '0;
    cyc();
    check("t3_ack_one_cycle", 32'(bus.irq_ack), 0);
    check("t3_irq_step1",     32'(bus.step), 1);
    check("t3_still_active",  32'(bus.irq_active), 1);
    bus.done = 1; bus.d_in = 8'h66;
    cyc();
    check("t3_reti_active", 32'(bus.irq_active), 0);
    check("t3_reti_ir",     32'(bus.ir), 'h66);

    // 4. Priority, and no re-evaluation at the end of dispatch.
    bus.irq_pending = 5'b10110; bus.d_in = 8'h77;
    cyc();
    check("t4_idx", 32'(bus.irq_idx), 1);
    check("t4_ack", 32'(bus.irq_ack), 'b00010);
    bus.d_in = 8'h88;
    cyc();
    check("t4_exit_active", 32'(bus.irq_active), 0);
    check("t4_exit_ack",    32'(bus.irq_ack), 0);
    check("t4_exit_ir",     32'(bus.ir), 'h88);
    bus.ime = 0; bus.irq_pending = '0;

    // 5. HALT and wake paths.
    bus.halt = 1; bus.d_in = 8'h99;
    cyc();
    check("t5_halted",    32'(bus.halted), 1);
    check("t5_halt_ir",   32'(bus.ir), 'h88);
    bus.halt = 0; bus.is_cond = 1; bus.next_cond = 3'd4;
    cyc();
    check("t5_stay_halted", 32'(bus.halted), 1);
    check("t5_halt_step",   32'(bus.step), 0);
    bus.done = 0; bus.is_cond = 0;
    bus.irq_pending = 5'b00001; bus.d_in = 8'h00;
    cyc();
    check("t5_wake_halted", 32'(bus.halted), 0);
    check("t5_wake_active", 32'(bus.irq_active), 0);
    check("t5_wake_ir",     32'(bus.ir), 'h00);
    check("t5_wake_noack",  32'(bus.irq_ack), 0);
    bus.irq_pending = '0; bus.done = 1; bus.halt = 1;
    cyc();
    check("t5_halted2", 32'(bus.halted), 1);
    bus.done = 0; bus.halt = 0; bus.ime = 1; bus.irq_pending = 5'b00001;
    cyc();
    check("t5_irq_active", 32'(bus.irq_active), 1);
    check("t5_irq_idx",    32'(bus.irq_idx), 0);
    check("t5_irq_ack",    32'(bus.irq_ack), 'b00001);
    bus.irq_pending = '0; bus.ime = 0; bus.done = 1; bus.d_in = 8'h00;
    cyc();
    // prefix beats halt.
    bus.prefix = 1; bus.halt = 1; bus.d_in = 8'hCB;
    cyc();
    check("t5_pfx_wins_halted", 32'(bus.halted), 0);
    check("t5_pfx_wins_flag",   32'(bus.ir_prefix), 1);
    check("t5_pfx_wins_ir",     32'(bus.ir), 'hCB);
    bus.prefix = 0; bus.halt = 0; bus.d_in = 8'h01;
    cyc();
    check("t5_pfx_cleared", 32'(bus.ir_prefix), 0);

    // 6. Stall then step overflow.
    bus.done = 0;
    repeat (5) cyc();
    check("t6_step5", 32'(bus.step), 5);
    bus.stall = 1; bus.done = 1; bus.d_in = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t6_stall_step", 32'(bus.step), 5);
      check("t6_stall_ir",   32'(bus.ir), 'h01);
    end
    bus.stall = 0; bus.done = 0;
    cyc();
    check("t6_step6", 32'(bus.step), 6);
    cyc();
    check("t6_step7",      32'(bus.step), 7);
    check("t6_no_err_yet", 32'(bus.seq_err), 0);
    cyc();
    check("t6_wrap_step", 32'(bus.step), 0);
    check("t6_wrap_err",  32'(bus.seq_err), 1);
    bus.done = 1; bus.d_in = 8'h02;
    cyc();
    check("t6_err_sticky", 32'(bus.seq_err), 1);
    bus.done = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_err_cleared", 32'(bus.seq_err), 0);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
